// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_line_fetch
// Description : Ping-pong line buffer between the framebuffer memory and the
//               VGA pins. While line v is shown from one bank, line v+1 is
//               fetched word by word into the other bank. Colour and sync
//               outputs are registered so they leave on the same cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                  pixel clock, asynchronous active-high reset
//   h_pxl_count, v_pxl_count  position from the timing counters
//   h_sync_in, v_sync_in      active-low syncs from the timing generator
//   mem_req_valid/ready/addr  word read request channel
//   mem_rsp_valid/data        read response channel (8 pixels x {r,g,b})
//   underrun_clr              clears the sticky underrun flag
//   red, green, blue          pixel colour, one cycle after the position
//   h_sync, v_sync            syncs delayed by one cycle
//   underrun                  sticky: a fill was still busy at a trigger
// Optional feature:
//   VGA_LINE_FETCH_TEST_PATTERN_EN adds input pattern_sel; when high the
//   visible colour is h_pxl_count[5:3] (8-pixel-wide vertical bars).
// ============================================================================
module vga_line_fetch #(
  parameter int H_VIS_AREA_PXL    = 200,
  parameter int H_NUM_BITS        = 9,
  parameter int V_VIS_AREA_PXL    = 600,
  parameter int V_WHOLE_FRAME_PXL = 628,
  parameter int V_NUM_BITS        = 10,
  parameter int PIX_PER_WORD      = 8,
  parameter int ADDR_BITS         = 16,
  parameter int FB_BASE           = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [H_NUM_BITS-1:0]     h_pxl_count,
  input  logic [V_NUM_BITS-1:0]     v_pxl_count,
  input  logic                      h_sync_in,
  input  logic                      v_sync_in,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_BITS-1:0]      mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [3*PIX_PER_WORD-1:0] mem_rsp_data,
  input  logic                      underrun_clr,
`ifdef VGA_LINE_FETCH_TEST_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  output logic                      red,
  output logic                      green,
  output logic                      blue,
  output logic                      h_sync,
  output logic                      v_sync,
  output logic                      underrun
);

  localparam int WORDS_PER_LINE = H_VIS_AREA_PXL / PIX_PER_WORD;
  localparam int WORD_W         = $clog2(WORDS_PER_LINE + 1);
  localparam int PIX_IDX_W      = $clog2(H_VIS_AREA_PXL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [V_NUM_BITS-1:0] fill_line, fill_line_nxt;
  logic [WORD_W-1:0]     word_idx, word_idx_nxt;
  logic [ADDR_BITS-1:0]  addr_nxt;
  logic                  bank_we;
  logic                  underrun_set;

  logic [V_NUM_BITS-1:0] target_line;
  logic                  trigger;
  logic                  fill_start;
  logic [WORD_W-1:0]     word_inc;

  logic [2:0]            bank [2][H_VIS_AREA_PXL];
  logic [PIX_IDX_W-1:0]  rd_idx;
  logic                  visible;
  logic [2:0]            pix_sel;

  // Word address of word w of line n, wrapped to the address width.
  function automatic logic [ADDR_BITS-1:0] word_addr(
    input logic [V_NUM_BITS-1:0] line,
    input logic [WORD_W-1:0]     w
  );
    logic [31:0] full;
    full = 32'(FB_BASE) + 32'(line) * 32'(WORDS_PER_LINE) + 32'(w);
    return full[ADDR_BITS-1:0];
  endfunction

  // The line after the last frame line is line 0 of the next frame.
  assign target_line = (v_pxl_count == V_NUM_BITS'(V_WHOLE_FRAME_PXL - 1))
                     ? '0 : v_pxl_count + V_NUM_BITS'(1);
  assign trigger     = (h_pxl_count == '0);
  assign fill_start  = trigger && (target_line < V_NUM_BITS'(V_VIS_AREA_PXL));
  assign word_inc    = word_idx + WORD_W'(1);

  // --------------------------------------------------------------------------
  // Fill FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    fill_line_nxt = fill_line;
    word_idx_nxt  = word_idx;
    addr_nxt      = mem_req_addr;
    bank_we       = 1'b0;
    mem_req_valid = 1'b0;
    // A trigger arriving while busy is dropped; the running fill finishes.
    underrun_set  = trigger && (state != IDLE);

    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt     = REQ;
          fill_line_nxt = target_line;
          word_idx_nxt  = '0;
          addr_nxt      = word_addr(target_line, '0);
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          bank_we      = 1'b1;
          word_idx_nxt = word_inc;
          if (word_inc < WORD_W'(WORDS_PER_LINE)) begin
            state_nxt = REQ;
            addr_nxt  = word_addr(fill_line, word_inc);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fill_line    <= '0;
      word_idx     <= '0;
      mem_req_addr <= '0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nxt;
      fill_line    <= fill_line_nxt;
      word_idx     <= word_idx_nxt;
      mem_req_addr <= addr_nxt;
      // Set wins over a simultaneous clear.
      if (underrun_set) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line banks: line n lives in bank n[0]. Contents are not reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (bank_we) begin
      for (int k = 0; k < PIX_PER_WORD; k++) begin
        bank[fill_line[0]][PIX_IDX_W'(int'(word_idx) * PIX_PER_WORD + k)]
          <= mem_rsp_data[3*k +: 3];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display stage
  // --------------------------------------------------------------------------
  assign rd_idx  = h_pxl_count[PIX_IDX_W-1:0];
  assign visible = (h_pxl_count < H_NUM_BITS'(H_VIS_AREA_PXL)) &&
                   (v_pxl_count < V_NUM_BITS'(V_VIS_AREA_PXL));

  always_comb begin
    pix_sel = 3'b000;
    if (visible) begin
`ifdef VGA_LINE_FETCH_TEST_PATTERN_EN
      if (pattern_sel) begin
        pix_sel = h_pxl_count[5:3];
      end else begin
        pix_sel = bank[v_pxl_count[0]][rd_idx];
      end
`else
      pix_sel = bank[v_pxl_count[0]][rd_idx];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red    <= 1'b0;
      green  <= 1'b0;
      blue   <= 1'b0;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
    end else begin
      red    <= pix_sel[2];
      green  <= pix_sel[1];
      blue   <= pix_sel[0];
      h_sync <= h_sync_in;
      v_sync <= v_sync_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_line_fetch
// Description : Self-checking bench for vga_line_fetch with a one-outstanding
//               memory model (configurable ready and response latency,
//               data derived from the word address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_line_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  h_pxl_count;
  logic [9:0]  v_pxl_count;
  logic        h_sync_in, v_sync_in;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [23:0] mem_rsp_data  = '0;
  logic        underrun_clr;
  logic        red, green, blue, h_sync, v_sync, underrun;
`ifdef VGA_LINE_FETCH_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_line_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .h_pxl_count   (h_pxl_count),
    .v_pxl_count   (v_pxl_count),
    .h_sync_in     (h_sync_in),
    .v_sync_in     (v_sync_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .underrun_clr  (underrun_clr),
`ifdef VGA_LINE_FETCH_TEST_PATTERN_EN
    .pattern_sel   (pattern_sel),
`endif
    .red           (red),
    .green         (green),
    .blue          (blue),
    .h_sync        (h_sync),
    .v_sync        (v_sync),
    .underrun      (underrun)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Pixel k of word a is (a + k) mod 8.
  function automatic logic [23:0] word_pattern(input logic [15:0] a);
    logic [23:0] d;
    for (int k = 0; k < 8; k++) d[3*k +: 3] = 3'(int'(a) + k);
    return d;
  endfunction

  // Expected pixel p of line n (25 words per line, base 0).
  function automatic logic [2:0] line_pix(input int n, input int p);
    return 3'(n * 25 + p / 8 + p % 8);
  endfunction

  // --------------------------------------------------------------------------
  // Memory model + request-address scoreboard
  // --------------------------------------------------------------------------
  bit          ready_en = 1'b1;
  int          lat      = 2;
  bit          pending  = 1'b0;
  int          countdown;
  logic [15:0] rsp_addr;
  int          hs_cnt   = 0;
  logic [15:0] exp_addr_q[$];

  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (pending) begin
      if (countdown <= 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_pattern(rsp_addr);
        pending       = 1'b0;
      end else begin
        countdown--;
      end
    end
    mem_req_ready = ready_en;
    if (mem_req_valid && mem_req_ready && !rst) begin
      hs_cnt++;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_req_addr", 32'(mem_req_addr), 32'hFFFF_FFFF);
      end else begin
        check("req_addr", 32'(mem_req_addr), 32'(exp_addr_q.pop_front()));
      end
      rsp_addr  = mem_req_addr;
      pending   = 1'b1;
      countdown = lat;
    end
  end

  // --------------------------------------------------------------------------
  // Display scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    int         h;
    int         v;
  } disp_exp_t;
  disp_exp_t disp_q[$];

  task automatic disp(input int h, input int v, input logic hs, input logic vs,
                      input logic [2:0] exp_rgb);
    disp_exp_t e;
    h_pxl_count = 9'(h);
    v_pxl_count = 10'(v);
    h_sync_in   = hs;
    v_sync_in   = vs;
    e.rgb = exp_rgb; e.hs = hs; e.vs = vs; e.h = h; e.v = v;
    disp_q.push_back(e);
    @(negedge clk);
    e = disp_q.pop_front();
    check($sformatf("rgb h=%0d v=%0d", e.h, e.v), 32'({red, green, blue}), 32'(e.rgb));
    check($sformatf("h_sync h=%0d", e.h), 32'(h_sync), 32'(e.hs));
    check($sformatf("v_sync h=%0d", e.h), 32'(v_sync), 32'(e.vs));
  endtask

  // One cycle at h = 0 on line v, then move off h = 0.
  task automatic trigger(input int v);
    h_pxl_count = 9'd0;
    v_pxl_count = 10'(v);
    @(negedge clk);
    h_pxl_count = 9'd1;
  endtask

  task automatic push_line(input int n);
    for (int w = 0; w < 25; w++) exp_addr_q.push_back(16'(n * 25 + w));
  endtask

  task automatic wait_fill_done(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || pending || mem_req_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int         h;
    int         v;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    rst          = 1'b1;
    h_pxl_count  = 9'd1;
    v_pxl_count  = 10'd0;
    h_sync_in    = 1'b0;
    v_sync_in    = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_rgb",      32'({red, green, blue}), 32'd0);
    check("reset_valid",    32'(mem_req_valid), 32'd0);
    check("reset_addr",     32'(mem_req_addr), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_h_sync",   32'(h_sync), 32'd1);
    check("reset_v_sync",   32'(v_sync), 32'd1);
    rst       = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    @(negedge clk);

    // Last frame line wraps to line 0: addresses 0..24
    base = hs_cnt;
    push_line(0);
    trigger(627);
    wait_fill_done(300, "fill_line0");
    check("fill_line0_reqs", 32'(hs_cnt - base), 32'd25);
    disp(5, 0, 1'b1, 1'b1, 3'd5);

    // v = 10 fetches line 11: addresses 275..299
    base = hs_cnt;
    push_line(11);
    trigger(10);
    wait_fill_done(300, "fill_line11");
    check("fill_line11_reqs", 32'(hs_cnt - base), 32'd25);

    // Table: bank 0 holds line 0, bank 1 holds line 11
    vecs[0]  = '{5,   0,   1'b1, 1'b1, line_pix(0, 5)};
    vecs[1]  = '{17,  0,   1'b0, 1'b1, line_pix(0, 17)};
    vecs[2]  = '{199, 0,   1'b1, 1'b0, line_pix(0, 199)};
    vecs[3]  = '{100, 0,   1'b0, 1'b0, line_pix(0, 100)};
    vecs[4]  = '{200, 0,   1'b1, 1'b1, 3'd0};
    vecs[5]  = '{205, 0,   1'b0, 1'b1, 3'd0};
    vecs[6]  = '{8,   11,  1'b1, 1'b1, line_pix(11, 8)};
    vecs[7]  = '{63,  11,  1'b1, 1'b0, line_pix(11, 63)};
    vecs[8]  = '{199, 11,  1'b0, 1'b0, line_pix(11, 199)};
    vecs[9]  = '{1,   11,  1'b1, 1'b1, line_pix(11, 1)};
    vecs[10] = '{5,   600, 1'b1, 1'b1, 3'd0};
    vecs[11] = '{5,   627, 1'b0, 1'b0, 3'd0};
    for (int i = 0; i < 12; i++) begin
      disp(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].rgb);
    end
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;

    // Back-pressure: request held stable, nothing accepted
    ready_en = 1'b0;
    base = hs_cnt;
    push_line(12);
    trigger(11);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(mem_req_valid), 32'd1);
      check("stall_addr",  32'(mem_req_addr), 32'd300);
      check("stall_no_hs", 32'(hs_cnt - base), 32'd0);
      @(negedge clk);
    end
    ready_en = 1'b1;
    wait_fill_done(300, "fill_line12");
    check("fill_line12_reqs", 32'(hs_cnt - base), 32'd25);

    // Slow memory: next trigger lands mid-fill
    lat  = 20;
    base = hs_cnt;
    push_line(13);
    trigger(12);
    repeat (100) @(negedge clk);
    check("underrun_before", 32'(underrun), 32'd0);
    trigger(13);
    check("underrun_set", 32'(underrun), 32'd1);
    repeat (5) @(negedge clk);
    check("underrun_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);
    h_pxl_count  = 9'd0;
    underrun_clr = 1'b1;
    @(negedge clk);
    h_pxl_count  = 9'd1;
    underrun_clr = 1'b0;
    check("underrun_set_wins", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared2", 32'(underrun), 32'd0);
    wait_fill_done(1500, "fill_line13");
    check("fill_line13_reqs", 32'(hs_cnt - base), 32'd25);
    check("underrun_after_fill", 32'(underrun), 32'd0);

    // Reset while waiting for a response; the late response is ignored
    lat  = 8;
    base = hs_cnt;
    exp_addr_q.push_back(16'd350);
    trigger(13);
    n = 0;
    while (hs_cnt == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_handshake_in_time", 32'(n < 20), 32'd1);
    @(negedge clk);
    rst         = 1'b1;
    v_pxl_count = 10'd610;
    @(negedge clk);
    check("in_rst_valid", 32'(mem_req_valid), 32'd0);
    check("in_rst_addr",  32'(mem_req_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_valid",    32'(mem_req_valid), 32'd0);
    check("post_rst_addr",     32'(mem_req_addr), 32'd0);
    check("post_rst_no_req",   32'(hs_cnt - base), 32'd1);
    check("post_rst_rgb",      32'({red, green, blue}), 32'd0);
    check("post_rst_underrun", 32'(underrun), 32'd0);
    exp_addr_q.delete();
    disp(5, 0, 1'b1, 1'b1, line_pix(12, 5));
    disp(2, 0, 1'b0, 1'b1, line_pix(12, 2));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
